// File: rtl/clk_div_prog_pkg.sv
// clk_div_prog_pkg: shared divider limits and the clamp rules applied to requested settings
package clk_div_prog_pkg;
  localparam logic [31:0] MIN_DIV  = 32'd2;
  localparam logic [31:0] MIN_HIGH = 32'd1;
  function automatic logic [31:0] clamp_div(input logic [31:0] n);
    return (n < MIN_DIV) ? MIN_DIV : n;
  endfunction
  function automatic logic [31:0] clamp_high(input logic [31:0] n, input logic [31:0] h);
    logic [31:0] cn;
    cn = clamp_div(n);
    return (h < MIN_HIGH) ? MIN_HIGH : (h >= cn) ? cn - 32'd1 : h;
  endfunction
endpackage

// File: rtl/clk_div_prog.sv
// clk_div_prog: programmable clock divider with shadowed period/high settings applied at period wrap
module clk_div_prog
  import clk_div_prog_pkg::*;
#(
  parameter int CNT_W    = 16,
  parameter int DEF_DIV  = 16,
  parameter int DEF_HIGH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [CNT_W-1:0] div_val,
  input  logic [CNT_W-1:0] high_val,
  output logic             outclk,
  output logic             tick,
  output logic             pending
);
  localparam logic [CNT_W-1:0] DEF_N = CNT_W'(clamp_div(32'(DEF_DIV)));
  localparam logic [CNT_W-1:0] DEF_H = CNT_W'(clamp_high(32'(DEF_DIV), 32'(DEF_HIGH)));
  logic [CNT_W-1:0] r_cnt, r_n, r_h, r_sn, r_sh;
  logic             r_out, r_tick, r_pend;
  logic [CNT_W-1:0] w_n, w_h;
  logic             w_wrap;
  assign w_n     = CNT_W'(clamp_div(32'(div_val)));
  assign w_h     = CNT_W'(clamp_high(32'(div_val), 32'(high_val)));
  assign w_wrap  = en && (r_cnt == r_n - CNT_W'(1));
  assign outclk  = r_out;
  assign tick    = r_tick;
  assign pending = r_pend;
  // period counter, phase compare and hand-over of captured settings at the period boundary
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_cnt  <= '0;
      r_out  <= 1'b0;
      r_tick <= 1'b0;
      r_pend <= 1'b0;
      r_n    <= DEF_N;
      r_h    <= DEF_H;
      r_sn   <= DEF_N;
      r_sh   <= DEF_H;
    end else if (!en) begin
      r_cnt  <= '0;
      r_out  <= 1'b0;
      r_tick <= 1'b0;
      r_pend <= 1'b0;
      if (load) {r_n, r_h, r_sn, r_sh} <= {w_n, w_h, w_n, w_h};
      else if (r_pend) {r_n, r_h} <= {r_sn, r_sh};
    end else begin
      r_cnt  <= w_wrap ? '0 : r_cnt + CNT_W'(1);
      r_out  <= r_cnt >= r_n - r_h;
      r_tick <= w_wrap;
      if (load) {r_sn, r_sh} <= {w_n, w_h};
      if (w_wrap) begin
        r_pend <= 1'b0;
        if (load) {r_n, r_h} <= {w_n, w_h};
        else if (r_pend) {r_n, r_h} <= {r_sn, r_sh};
      end else if (load) r_pend <= 1'b1;
    end
endmodule

// File: tb/tb_clk_div_prog.sv
// tb_clk_div_prog: directed stimulus with a period/high-count scoreboard driven by tick
module tb_clk_div_prog;
  logic        clk = 1'b0;
  logic        rst, en, load;
  logic [15:0] div_val, high_val;
  logic        outclk, tick, pending;
  int          checks = 0;
  int          failures = 0;
  typedef struct {int per; int hi;} exp_t;
  exp_t        q[$];
  logic        en_q = 1'b0;
  logic        rst_q = 1'b0;
  int          cyc = 0;
  int          hi = 0;

  clk_div_prog dut (
    .clk(clk), .rst(rst), .en(en), .load(load), .div_val(div_val), .high_val(high_val),
    .outclk(outclk), .tick(tick), .pending(pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic go(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input int per, input int h, input int n);
    exp_t e;
    e.per = per;
    e.hi  = h;
    repeat (n) q.push_back(e);
  endtask

  always @(posedge clk) begin
    en_q  <= en;
    rst_q <= rst;
  end

  // each tick closes a period: compare its length and high-cycle count with the next expectation
  always @(negedge clk) begin
    if (!rst || !rst_q || !en_q) begin
      cyc = 0;
      hi  = 0;
    end else begin
      cyc++;
      hi += int'(outclk);
      if (tick) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_tick: got period %0d with no expected period queued", cyc);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("period_len", cyc, e.per);
          chk("high_cycles", hi, e.hi);
        end
        cyc = 0;
        hi  = 0;
      end
    end
  end

  initial begin
    rst = 1'b0; en = 1'b0; load = 1'b0; div_val = '0; high_val = '0;
    go(3);
    chk("rst_outclk", outclk, 0);
    chk("rst_tick", tick, 0);
    chk("rst_pending", pending, 0);
    rst = 1'b1; en = 1'b1;
    push(16, 8, 3);
    go(8);
    chk("first_rise_early", outclk, 0);
    go(1);
    chk("first_rise", outclk, 1);
    go(27);
    load = 1'b1; div_val = 16'd10; high_val = 16'd3;
    go(1);
    load = 1'b0;
    chk("pending_set", pending, 1);
    push(10, 3, 2);
    go(10);
    chk("pending_hold", pending, 1);
    go(1);
    chk("pending_clear_wrap", pending, 0);
    chk("tick_at_wrap", tick, 1);
    go(19);
    load = 1'b1; div_val = 16'd1; high_val = 16'd0;
    push(2, 1, 4);
    go(1);
    load = 1'b0;
    chk("load_at_wrap_no_pending", pending, 0);
    go(6);
    load = 1'b1; div_val = 16'd5; high_val = 16'd9;
    go(1);
    load = 1'b0;
    chk("pending_small_n", pending, 1);
    push(5, 4, 3);
    go(11);
    load = 1'b1; div_val = 16'd7; high_val = 16'd2;
    go(1);
    div_val = 16'd12; high_val = 16'd6;
    go(1);
    load = 1'b0;
    go(3);
    chk("pending_b2b_clear", pending, 0);
    go(1);
    load = 1'b1; div_val = 16'd8; high_val = 16'd4;
    go(1);
    load = 1'b0;
    chk("pending_before_abort", pending, 1);
    go(4);
    en = 1'b0;
    go(1);
    chk("abort_outclk", outclk, 0);
    chk("abort_pending", pending, 0);
    push(8, 4, 1);
    go(2);
    chk("idle_tick", tick, 0);
    en = 1'b1;
    go(8);
    chk("restart_full_period", tick, 1);
    en = 1'b0;
    go(1);
    load = 1'b1; div_val = 16'd6; high_val = 16'd2;
    go(1);
    load = 1'b0;
    chk("idle_load_no_pending", pending, 0);
    push(6, 2, 1);
    en = 1'b1;
    go(6);
    load = 1'b1; div_val = 16'd3; high_val = 16'd1;
    go(1);
    load = 1'b0;
    go(4);
    chk("pre_rst_outclk", outclk, 1);
    chk("pre_rst_pending", pending, 1);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_outclk", outclk, 0);
    chk("async_rst_pending", pending, 0);
    push(16, 8, 1);
    go(2);
    rst = 1'b1;
    go(16);
    chk("post_rst_tick", tick, 1);
    go(2);
    chk("queue_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
